reg_dump: RTL and testbench

//  Debug-side master for the CPU register file. It bulk-reads the register file
//  (dump) or bulk-writes it (load) through the file's two read ports and one write port.

---
 rtl/reg_dump_pkg.sv | 16 +
 rtl/reg_dump.sv | 111 +++++++++++
 tb/tb_reg_dump.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared widths and FSM state encodings for reg_dump
package reg_dump_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND0 = 3'd2,
    ST_SEND1 = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - bulk dump/load master for the register file (two read ports, one write port)
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam int WORD_W = $clog2(NUM_REGS);
  localparam int PAIR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_REGS - 1);

  state_t                state;
  state_t                state_nx;
  logic [PAIR_W-1:0]     pair;
  logic [WORD_W-1:0]     word_idx;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  assign rf_raddr1 = ADDR_WIDTH'({pair, 1'b0});
  assign rf_raddr2 = ADDR_WIDTH'({pair, 1'b1});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = mode ? ST_LOAD : ST_FETCH;
      ST_FETCH: state_nx = ST_SEND0;
      ST_SEND0: if (out_ready) state_nx = ST_SEND1;
      ST_SEND1: if (out_ready) state_nx = (pair == LAST_PAIR) ? ST_DONE : ST_FETCH;
      ST_LOAD:  if (in_valid && (word_idx == LAST_WORD)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Stream outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    out_valid = (state == ST_SEND0) || (state == ST_SEND1);
    out_last  = (state == ST_SEND1) && (pair == LAST_PAIR);
    in_ready  = (state == ST_LOAD);
    out_data  = '0;
    if (state == ST_SEND0) out_data = buf0;
    if (state == ST_SEND1) out_data = buf1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pair     <= '0;
      word_idx <= '0;
      buf0     <= '0;
      buf1     <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= 1'b0;
      case (state)
        ST_FETCH: begin
          buf0 <= rf_rdata1;
          buf1 <= rf_rdata2;
        end
        ST_SEND1: if (out_ready && (pair != LAST_PAIR)) pair <= pair + 1'b1;
        ST_LOAD: begin
          if (in_valid) begin
            rf_wen   <= 1'b1;
            rf_waddr <= ADDR_WIDTH'(word_idx);
            rf_wdata <= in_data;
            // Saturate on the last word; DONE clears it, so the counter never wraps.
            if (word_idx != LAST_WORD) word_idx <= word_idx + 1'b1;
          end
        end
        ST_DONE: begin
          pair     <= '0;
          word_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - randomized scoreboard bench for reg_dump (32- and 8-register instances)
module tb_reg_dump;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        start_s[2], mode_s[2], out_ready_s[2], in_valid_s[2];
  logic [31:0] in_data_s[2], rf_rdata1_s[2], rf_rdata2_s[2], rf_wdata_s[2], out_data_s[2];
  logic        busy_s[2], done_s[2], rf_wen_s[2], out_valid_s[2], out_last_s[2], in_ready_s[2];
  logic [4:0]  rf_raddr1_s[2], rf_raddr2_s[2], rf_waddr_s[2];

  logic [31:0] rf [2][32];
  logic [31:0] mdl[2][32];
  logic        pre_en;

  int vectors = 0;
  int miscompares = 0;
  int act = 0;

  logic [32:0] dq[$];
  logic [37:0] wq[$];

  reg_dump #(.NUM_REGS(32)) u_dut (
    .clk(clk), .resetn(resetn), .start(start_s[0]), .mode(mode_s[0]),
    .busy(busy_s[0]), .done(done_s[0]),
    .rf_raddr1(rf_raddr1_s[0]), .rf_raddr2(rf_raddr2_s[0]),
    .rf_rdata1(rf_rdata1_s[0]), .rf_rdata2(rf_rdata2_s[0]),
    .rf_wen(rf_wen_s[0]), .rf_waddr(rf_waddr_s[0]), .rf_wdata(rf_wdata_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
    .out_last(out_last_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_data(in_data_s[0])
  );

  reg_dump #(.NUM_REGS(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .start(start_s[1]), .mode(mode_s[1]),
    .busy(busy_s[1]), .done(done_s[1]),
    .rf_raddr1(rf_raddr1_s[1]), .rf_raddr2(rf_raddr2_s[1]),
    .rf_rdata1(rf_rdata1_s[1]), .rf_rdata2(rf_rdata2_s[1]),
    .rf_wen(rf_wen_s[1]), .rf_waddr(rf_waddr_s[1]), .rf_wdata(rf_wdata_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
    .out_last(out_last_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_data(in_data_s[1])
  );

  // Register file far end: combinational reads, r0 never written.
  for (genvar g = 0; g < 2; g++) begin : g_rf
    assign rf_rdata1_s[g] = rf[g][rf_raddr1_s[g]];
    assign rf_rdata2_s[g] = rf[g][rf_raddr2_s[g]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pre_en) begin
        for (int i = 0; i < 32; i++) rf[k][i] <= 32'(i * 32'h11);
      end else if (rf_wen_s[k] && (rf_waddr_s[k] != 5'd0)) begin
        rf[k][rf_waddr_s[k]] <= rf_wdata_s[k];
      end
    end
  end

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Monitor: pops expected words/writes as the DUT presents them.
  logic        stall_prev, last_prev, hs_prev, done_due;
  logic [31:0] data_prev;
  always @(negedge clk) begin : mon
    logic [32:0] e;
    logic [37:0] w;
    logic        exp_done;
    logic        pop_last;
    if (!resetn) begin
      dq.delete();
      wq.delete();
      stall_prev <= 1'b0;
      hs_prev    <= 1'b0;
      done_due   <= 1'b0;
    end else begin
      exp_done = done_due;
      pop_last = 1'b0;
      if (stall_prev) begin
        chk("hold_valid", out_valid_s[act], 1'b1);
        chk("hold_data", out_data_s[act], data_prev);
        chk("hold_last", out_last_s[act], last_prev);
      end
      if (out_valid_s[act] && out_ready_s[act]) begin
        if (dq.size() == 0) chk("extra_word", 1, 0);
        else begin
          e = dq.pop_front();
          chk("out_data", out_data_s[act], e[31:0]);
          chk("out_last", out_last_s[act], e[32]);
          pop_last = e[32];
        end
      end
      chk("rf_wen_timing", rf_wen_s[act], hs_prev);
      if (rf_wen_s[act]) begin
        if (wq.size() == 0) chk("extra_write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("rf_waddr", rf_waddr_s[act], w[36:32]);
          chk("rf_wdata", rf_wdata_s[act], w[31:0]);
          if (w[37]) exp_done = 1'b1;
        end
      end
      chk("done", done_s[act], exp_done);
      done_due   <= pop_last;
      stall_prev <= out_valid_s[act] && !out_ready_s[act];
      data_prev  <= out_data_s[act];
      last_prev  <= out_last_s[act];
      hs_prev    <= in_valid_s[act] && in_ready_s[act];
    end
  end

  task automatic chk_zero(int k);
    chk("rst_busy", busy_s[k], 0);
    chk("rst_done", done_s[k], 0);
    chk("rst_wen", rf_wen_s[k], 0);
    chk("rst_valid", out_valid_s[k], 0);
    chk("rst_last", out_last_s[k], 0);
    chk("rst_in_ready", in_ready_s[k], 0);
    chk("rst_out_data", out_data_s[k], 0);
    chk("rst_waddr", rf_waddr_s[k], 0);
    chk("rst_wdata", rf_wdata_s[k], 0);
    chk("rst_raddr", {rf_raddr1_s[k], rf_raddr2_s[k]}, {5'd0, 5'd1});
  endtask

  task automatic run_dump(int k, bit rnd, bit poke, int abort_after);
    int n   = (k == 1) ? 8 : 32;
    int cyc = 0;
    int cnt = 0;
    act = k;
    for (int i = 0; i < n; i++) dq.push_back({(i == n - 1), mdl[k][i]});
    @(posedge clk); #1;
    start_s[k] = 1'b1; mode_s[k] = 1'b0;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    chk("dump_busy", busy_s[k], 1);
    chk("fetch_no_valid", out_valid_s[k], 0);
    out_ready_s[k] = 1'b0;
    @(posedge clk); #1;
    chk("first_valid", out_valid_s[k], 1);
    while (!done_s[k] && cyc < 2000) begin
      out_ready_s[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_s[k] = poke && (cyc == 7 || cyc == 20);
      mode_s[k]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid_s[k] && out_ready_s[k]) cnt++;
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && cnt == abort_after) begin
        out_ready_s[k] = 1'b0;
        start_s[k] = 1'b0;
        return;
      end
    end
    start_s[k] = 1'b0;
    out_ready_s[k] = 1'b0;
    chk("dump_finished", cyc < 2000, 1);
    chk("dump_words", cnt, n);
    chk("dq_empty", dq.size(), 0);
    @(posedge clk); #1;
    chk("dump_idle", busy_s[k], 0);
  endtask

  task automatic run_load(int k, bit poke, int stop);
    int n   = (k == 1) ? 8 : 32;
    int idx = 0;
    int cyc = 0;
    act = k;
    @(posedge clk); #1;
    start_s[k] = 1'b1; mode_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    chk("load_busy", busy_s[k], 1);
    while (idx < stop && cyc < 2000) begin
      in_valid_s[k] = ($urandom_range(0, 3) != 0);
      in_data_s[k]  = 32'hA000_0000 + 32'(idx);
      start_s[k]    = poke && (cyc == 5 || cyc == 17);
      mode_s[k]     = 1'b0;
      @(negedge clk);
      if (in_valid_s[k] && in_ready_s[k]) begin
        wq.push_back({(idx == n - 1), 5'(idx), in_data_s[k]});
        if (idx != 0) mdl[k][idx] = in_data_s[k];
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_s[k] = 1'b0;
    start_s[k] = 1'b0;
    chk("load_finished", cyc < 2000, 1);
    if (stop == n) begin
      chk("load_done", done_s[k], 1);
      @(posedge clk); #1;
      chk("load_idle", busy_s[k], 0);
      chk("wq_empty", wq.size(), 0);
    end
  endtask

  task automatic pulse_reset(int k);
    #2 resetn = 1'b0;
    #1 chk_zero(k);
    repeat (2) @(posedge clk);
    #1 chk_zero(k);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    pre_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; mode_s[k] = 0; out_ready_s[k] = 0; in_valid_s[k] = 0; in_data_s[k] = '0;
      for (int i = 0; i < 32; i++) mdl[k][i] = 32'(i * 32'h11);
    end
    #1 chk_zero(0);
    chk_zero(1);
    @(posedge clk); #1 pre_en = 1'b1;
    @(posedge clk); #1 pre_en = 1'b0;
    resetn = 1'b1;

    run_dump(0, 0, 0, 0);
    run_dump(0, 1, 1, 0);
    run_load(0, 1, 32);
    run_dump(0, 1, 0, 0);

    // Abort in SEND1 of pair 5 (after words 0..10 handshaken).
    run_dump(0, 0, 0, 11);
    chk("pre_rst_valid", out_valid_s[0], 1);
    chk("pre_rst_last", out_last_s[0], 0);
    pulse_reset(0);
    run_dump(0, 0, 0, 0);

    // Abort while LOAD waits for word 10; writes 0..9 have landed.
    run_load(0, 0, 10);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_in_ready", in_ready_s[0], 1);
    chk("wq_drained", wq.size(), 0);
    pulse_reset(0);
    repeat (3) @(posedge clk);
    #1 run_dump(0, 1, 0, 0);

    run_dump(1, 0, 0, 0);
    run_load(1, 0, 8);
    run_dump(1, 1, 1, 0);
    run_load(1, 1, 8);
    run_dump(1, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
